// File: rtl/bcd_updown_counter_if.sv
// Bus bundle for bcd_updown_counter: count control, load data, count and status.
// The counter drives q/tc/err/cout through the slave modport; the user drives
// en/dir/ld/d through the master modport.
interface bcd_updown_counter_if #(
   parameter int DIGITS = 4
);
   logic                en;
   logic                dir;
   logic                ld;
   logic [4*DIGITS-1:0] d;
   logic [4*DIGITS-1:0] q;
   logic                tc;
   logic                err;
   logic                cout;

   modport master (output en, dir, ld, d, input q, tc, err, cout);
   modport slave  (input en, dir, ld, d, output q, tc, err, cout);
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with count enable, synchronous parallel load
// with digit validation, terminal-count pulse and cascade carry/borrow.
// Optional feature macro: BCD_UPDOWN_COUNTER_SAT_EN -- when defined the count
// saturates at all-9s (up) or 0 (down) instead of wrapping, and cout is tied low.
module bcd_updown_counter #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                clr,
   bcd_updown_counter_if.slave bus
);
   localparam int           W         = 4 * DIGITS;
   localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

   logic [W-1:0] q_q, q_d;
   logic         tc_q, tc_d;
   logic         err_q, err_d;
   logic [W-1:0] inc_val, dec_val, load_val;
   logic         load_bad;
   logic         at_max, at_zero;

   assign at_max  = (q_q == ALL_NINES);
   assign at_zero = (q_q == '0);

   // Decimal +1 and -1 of the current count, rippling carry/borrow one nibble at a time.
   always_comb begin : arith
      logic carry;
      logic borrow;
      // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      inc_val = q_q;
      dec_val = q_q;
      carry   = 1'b1;
      borrow  = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (q_q[4*k +: 4] == 4'd9) begin
               inc_val[4*k +: 4] = 4'd0;
            end else begin
               inc_val[4*k +: 4] = q_q[4*k +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
         if (borrow) begin
            if (q_q[4*k +: 4] == 4'd0) begin
               dec_val[4*k +: 4] = 4'd9;
            end else begin
               dec_val[4*k +: 4] = q_q[4*k +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
   end

   // Load value with every non-decimal digit forced to 0, plus the invalid-digit flag.
   always_comb begin : sanitise
      load_val = bus.d;
      load_bad = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (bus.d[4*k +: 4] > 4'd9) begin
            load_val[4*k +: 4] = 4'd0;
            load_bad           = 1'b1;
         end
      end
   end

   // Next count and status pulses: load beats count, count beats hold.
   always_comb begin : next_state
      q_d   = q_q;
      tc_d  = 1'b0;
      err_d = 1'b0;
      if (bus.ld) begin
         q_d   = load_val;
         err_d = load_bad;
      end else if (bus.en) begin
         if (bus.dir) begin
`ifdef BCD_UPDOWN_COUNTER_SAT_EN
            if (!at_max) q_d = inc_val;
`else
            q_d = inc_val;
`endif
            tc_d = at_max;
         end else begin
`ifdef BCD_UPDOWN_COUNTER_SAT_EN
            if (!at_zero) q_d = dec_val;
`else
            q_d = dec_val;
`endif
            tc_d = at_zero;
         end
      end
   end

   // Count and status registers, cleared asynchronously by clr.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge clr) begin : regs
      if (!clr) begin
         q_q   <= '0;
         tc_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         tc_q  <= tc_d;
         err_q <= err_d;
      end
   end

   assign bus.q   = q_q;
   assign bus.tc  = tc_q;
   assign bus.err = err_q;

`ifdef BCD_UPDOWN_COUNTER_SAT_EN
   // A saturating counter never hands a carry on, so cascading is disabled.
   assign bus.cout = 1'b0;
`else
   // High exactly in the cycle before a wrap; feeds en of the next-higher decade group.
   assign bus.cout = bus.en & ~bus.ld & (bus.dir ? at_max : at_zero);
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter. The reference model keeps the count
// as a plain integer and applies decimal +1/-1 with wrap (or saturation when
// BCD_UPDOWN_COUNTER_SAT_EN is defined); BCD packing is derived only for comparison.
module tb_bcd_updown_counter;
   localparam int unsigned MAXV = 9999;

   logic clk;
   logic clr;
   int   total = 0;
   int   bad   = 0;

   int unsigned m_val;
   bit          m_tc;
   bit          m_err;

   bcd_updown_counter_if #(.DIGITS(4)) bus4 ();
   bcd_updown_counter_if #(.DIGITS(2)) cas_lo ();
   bcd_updown_counter_if #(.DIGITS(2)) cas_hi ();

   bcd_updown_counter #(.DIGITS(4)) dut (.clk(clk), .clr(clr), .bus(bus4));
   bcd_updown_counter #(.DIGITS(2)) u_lo (.clk(clk), .clr(clr), .bus(cas_lo));
   bcd_updown_counter #(.DIGITS(2)) u_hi (.clk(clk), .clr(clr), .bus(cas_hi));

   assign cas_hi.en  = cas_lo.cout;
   assign cas_hi.dir = cas_lo.dir;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic logic [15:0] to_bcd(input int unsigned v);
      logic [15:0] r;
      int unsigned t;
      t = v;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int unsigned load_value(input logic [15:0] dv, output bit any_bad);
      int unsigned v, scale, dig;
      v = 0;
      scale = 1;
      any_bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         dig = 32'(dv[4*k +: 4]);
         if (dig > 9) begin
            any_bad = 1'b1;
            dig = 0;
         end
         v = v + dig * scale;
         scale = scale * 10;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_val = 0;
      m_tc  = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic model_step(input bit l, input bit e, input bit dr, input logic [15:0] dv);
      m_tc  = 1'b0;
      m_err = 1'b0;
      if (l) begin
         m_val = load_value(dv, m_err);
      end else if (e && dr) begin
         if (m_val == MAXV) begin
            m_tc = 1'b1;
`ifndef BCD_UPDOWN_COUNTER_SAT_EN
            m_val = 0;
`endif
         end else begin
            m_val = m_val + 1;
         end
      end else if (e) begin
         if (m_val == 0) begin
            m_tc = 1'b1;
`ifndef BCD_UPDOWN_COUNTER_SAT_EN
            m_val = MAXV;
`endif
         end else begin
            m_val = m_val - 1;
         end
      end
   endtask

   function automatic bit exp_cout(input bit l, input bit e, input bit dr);
      bit c;
      c = e && !l && (dr ? (m_val == MAXV) : (m_val == 0));
`ifdef BCD_UPDOWN_COUNTER_SAT_EN
      c = 1'b0;
`endif
      return c;
   endfunction

   // Drive one cycle of stimulus; returns cout seen before the edge. Ends 1 time unit after the edge.
   task automatic do_cycle(input bit l, input bit e, input bit dr, input logic [15:0] dv,
                           output logic cout_seen);
      bus4.ld  = l;
      bus4.en  = e;
      bus4.dir = dr;
      bus4.d   = dv;
      #1;
      cout_seen = bus4.cout;
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic c;
      #2;
      total++; if (bus4.q !== 16'h0000) begin bad++; $display("FAIL reset_q: got %h expected 0000", bus4.q); end
      total++; if (bus4.tc !== 1'b0) begin bad++; $display("FAIL reset_tc: got %b expected 0", bus4.tc); end
      total++; if (bus4.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", bus4.err); end
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      do_cycle(1'b1, 1'b0, 1'b0, 16'h0042, c); model_step(1'b1, 1'b0, 1'b0, 16'h0042);
      do_cycle(1'b0, 1'b1, 1'b1, 16'h0000, c); model_step(1'b0, 1'b1, 1'b1, 16'h0000);
      do_cycle(1'b1, 1'b0, 1'b0, 16'h5B21, c); model_step(1'b1, 1'b0, 1'b0, 16'h5B21);
      total++; if (bus4.q !== to_bcd(m_val)) begin bad++; $display("FAIL pre_reset_q: got %h expected %h", bus4.q, to_bcd(m_val)); end
      total++; if (bus4.err !== m_err) begin bad++; $display("FAIL pre_reset_err: got %b expected %b", bus4.err, m_err); end
      // keep counting, then pull clr low mid-cycle
      bus4.ld = 1'b0; bus4.en = 1'b1; bus4.dir = 1'b1;
      #1;
      clr = 1'b0;
      #1;
      model_reset();
      total++; if (bus4.q !== to_bcd(m_val)) begin bad++; $display("FAIL async_clr_q: got %h expected %h", bus4.q, to_bcd(m_val)); end
      total++; if (bus4.tc !== m_tc) begin bad++; $display("FAIL async_clr_tc: got %b expected %b", bus4.tc, m_tc); end
      total++; if (bus4.err !== m_err) begin bad++; $display("FAIL async_clr_err: got %b expected %b", bus4.err, m_err); end
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      model_step(1'b0, 1'b1, 1'b1, 16'h0000);
      total++; if (bus4.q !== to_bcd(m_val)) begin bad++; $display("FAIL after_release_q: got %h expected %h", bus4.q, to_bcd(m_val)); end
   endtask

   task automatic test_up_wrap();
      logic c;
      bit   ce;
      do_cycle(1'b1, 1'b0, 1'b1, 16'h9998, c); model_step(1'b1, 1'b0, 1'b1, 16'h9998);
      for (int i = 0; i < 2; i++) begin
         ce = exp_cout(1'b0, 1'b1, 1'b1);
         do_cycle(1'b0, 1'b1, 1'b1, 16'h0000, c);
         model_step(1'b0, 1'b1, 1'b1, 16'h0000);
         total++; if (c !== ce) begin bad++; $display("FAIL up_wrap_cout[%0d]: got %b expected %b", i, c, ce); end
         total++; if (bus4.q !== to_bcd(m_val)) begin bad++; $display("FAIL up_wrap_q[%0d]: got %h expected %h", i, bus4.q, to_bcd(m_val)); end
         total++; if (bus4.tc !== m_tc) begin bad++; $display("FAIL up_wrap_tc[%0d]: got %b expected %b", i, bus4.tc, m_tc); end
      end
   endtask

   task automatic test_down_borrow();
      logic        c;
      bit          ce;
      logic [15:0] loads [2];
      loads[0] = 16'h1000;
      loads[1] = 16'h0000;
      for (int i = 0; i < 2; i++) begin
         do_cycle(1'b1, 1'b0, 1'b0, loads[i], c); model_step(1'b1, 1'b0, 1'b0, loads[i]);
         ce = exp_cout(1'b0, 1'b1, 1'b0);
         do_cycle(1'b0, 1'b1, 1'b0, 16'h0000, c);
         model_step(1'b0, 1'b1, 1'b0, 16'h0000);
         total++; if (c !== ce) begin bad++; $display("FAIL down_cout[%0d]: got %b expected %b", i, c, ce); end
         total++; if (bus4.q !== to_bcd(m_val)) begin bad++; $display("FAIL down_q[%0d]: got %h expected %h", i, bus4.q, to_bcd(m_val)); end
         total++; if (bus4.tc !== m_tc) begin bad++; $display("FAIL down_tc[%0d]: got %b expected %b", i, bus4.tc, m_tc); end
      end
   endtask

   task automatic test_invalid_load();
      logic c;
      bit   ce;
      do_cycle(1'b1, 1'b0, 1'b0, 16'h1A3F, c); model_step(1'b1, 1'b0, 1'b0, 16'h1A3F);
      total++; if (bus4.q !== to_bcd(m_val)) begin bad++; $display("FAIL bad_load_q: got %h expected %h", bus4.q, to_bcd(m_val)); end
      total++; if (bus4.err !== m_err) begin bad++; $display("FAIL bad_load_err: got %b expected %b", bus4.err, m_err); end
      do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, c); model_step(1'b0, 1'b0, 1'b0, 16'h0000);
      total++; if (bus4.err !== m_err) begin bad++; $display("FAIL bad_load_err_pulse: got %b expected %b", bus4.err, m_err); end
      // load wins over a pending wrap
      do_cycle(1'b1, 1'b0, 1'b1, 16'h9999, c); model_step(1'b1, 1'b0, 1'b1, 16'h9999);
      ce = exp_cout(1'b1, 1'b1, 1'b1);
      do_cycle(1'b1, 1'b1, 1'b1, 16'h1234, c); model_step(1'b1, 1'b1, 1'b1, 16'h1234);
      total++; if (c !== ce) begin bad++; $display("FAIL ld_wins_cout: got %b expected %b", c, ce); end
      total++; if (bus4.q !== to_bcd(m_val)) begin bad++; $display("FAIL ld_wins_q: got %h expected %h", bus4.q, to_bcd(m_val)); end
      total++; if (bus4.tc !== m_tc) begin bad++; $display("FAIL ld_wins_tc: got %b expected %b", bus4.tc, m_tc); end
   endtask

   task automatic test_hold();
      logic c;
      bit   dr;
      do_cycle(1'b1, 1'b0, 1'b0, 16'h04F7, c); model_step(1'b1, 1'b0, 1'b0, 16'h04F7);
      for (int i = 0; i < 3; i++) begin
         dr = 1'($urandom);
         do_cycle(1'b0, 1'b0, dr, 16'($urandom), c);
         model_step(1'b0, 1'b0, dr, 16'h0000);
         total++; if (c !== 1'b0) begin bad++; $display("FAIL hold_cout[%0d]: got %b expected 0", i, c); end
         total++; if (bus4.q !== to_bcd(m_val)) begin bad++; $display("FAIL hold_q[%0d]: got %h expected %h", i, bus4.q, to_bcd(m_val)); end
         total++; if ({bus4.tc, bus4.err} !== {m_tc, m_err}) begin bad++; $display("FAIL hold_flags[%0d]: got %b%b expected %b%b", i, bus4.tc, bus4.err, m_tc, m_err); end
      end
   endtask

   task automatic test_saturation();
      logic c;
      bit   ce;
      do_cycle(1'b1, 1'b0, 1'b1, 16'h9999, c); model_step(1'b1, 1'b0, 1'b1, 16'h9999);
      for (int i = 0; i < 3; i++) begin
         ce = exp_cout(1'b0, 1'b1, 1'b1);
         do_cycle(1'b0, 1'b1, 1'b1, 16'h0000, c);
         model_step(1'b0, 1'b1, 1'b1, 16'h0000);
         total++; if (c !== ce) begin bad++; $display("FAIL top_cout[%0d]: got %b expected %b", i, c, ce); end
         total++; if (bus4.q !== to_bcd(m_val)) begin bad++; $display("FAIL top_q[%0d]: got %h expected %h", i, bus4.q, to_bcd(m_val)); end
         total++; if (bus4.tc !== m_tc) begin bad++; $display("FAIL top_tc[%0d]: got %b expected %b", i, bus4.tc, m_tc); end
      end
   endtask

   task automatic test_random();
      logic        c;
      bit          ce, l, e, dr;
      logic [15:0] dv;
      for (int i = 0; i < 500; i++) begin
         l  = ($urandom_range(0, 9) == 0);
         e  = ($urandom_range(0, 3) != 0);
         dr = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       dv = 16'h9999;
            1:       dv = 16'h0000;
            2:       dv = 16'h0999;
            default: dv = 16'($urandom);
         endcase
         ce = exp_cout(l, e, dr);
         do_cycle(l, e, dr, dv, c);
         model_step(l, e, dr, dv);
         total++; if (c !== ce) begin bad++; $display("FAIL rand_cout[%0d]: got %b expected %b", i, c, ce); end
         total++; if (bus4.q !== to_bcd(m_val)) begin bad++; $display("FAIL rand_q[%0d]: got %h expected %h", i, bus4.q, to_bcd(m_val)); end
         total++; if (bus4.tc !== m_tc) begin bad++; $display("FAIL rand_tc[%0d]: got %b expected %b", i, bus4.tc, m_tc); end
         total++; if (bus4.err !== m_err) begin bad++; $display("FAIL rand_err[%0d]: got %b expected %b", i, bus4.err, m_err); end
      end
   endtask

   task automatic test_cascade();
      logic [15:0] exp_q;
      bit          exp_lo_cout;
`ifdef BCD_UPDOWN_COUNTER_SAT_EN
      exp_q       = 16'h0099;
      exp_lo_cout = 1'b0;
`else
      exp_q       = 16'h0100;
      exp_lo_cout = 1'b1;
`endif
      cas_lo.ld = 1'b1; cas_lo.en = 1'b0; cas_lo.dir = 1'b1; cas_lo.d = 8'h99;
      cas_hi.ld = 1'b1; cas_hi.d = 8'h00;
      @(posedge clk);
      #1;
      cas_lo.ld = 1'b0; cas_hi.ld = 1'b0; cas_lo.en = 1'b1;
      #1;
      total++; if (cas_lo.cout !== exp_lo_cout) begin bad++; $display("FAIL cascade_cout: got %b expected %b", cas_lo.cout, exp_lo_cout); end
      @(posedge clk);
      #1;
      cas_lo.en = 1'b0;
      total++; if ({cas_hi.q, cas_lo.q} !== exp_q) begin bad++; $display("FAIL cascade_q: got %h expected %h", {cas_hi.q, cas_lo.q}, exp_q); end
      total++; if (cas_lo.tc !== 1'b1) begin bad++; $display("FAIL cascade_lo_tc: got %b expected 1", cas_lo.tc); end
      total++; if (cas_hi.tc !== 1'b0) begin bad++; $display("FAIL cascade_hi_tc: got %b expected 0", cas_hi.tc); end
   endtask

   initial begin
      clr = 1'b0;
      bus4.ld = 1'b0; bus4.en = 1'b0; bus4.dir = 1'b1; bus4.d = '0;
      cas_lo.ld = 1'b0; cas_lo.en = 1'b0; cas_lo.dir = 1'b1; cas_lo.d = '0;
      cas_hi.ld = 1'b0; cas_hi.d = '0;
      model_reset();
      test_reset();
      test_up_wrap();
      test_down_borrow();
      test_invalid_load();
      test_hold();
      test_saturation();
      test_random();
      test_cascade();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
